// File: rtl/sum_bcd_display.sv
// Converts an unsigned adder result to two BCD digits with a one-shift-per-clock
// double-dabble engine and drives two active-low seven-segment displays.
module sum_bcd_display #(
   parameter int WIDTH    = 5,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [7:0]       bcd_out,
   output logic [6:0]       HEX0,
   output logic [6:0]       HEX1
);

   // Handshake: a value transfers only on a rising edge with in_valid & in_ready;
   // in_ready is high only in IDLE, so in_valid during CONV/DONE is ignored.

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [6:0] HEX1_RST  = BLANK_LZ ? SEG_BLANK : SEG_ZERO;

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] bin_q;
   logic [7:0]       scratch_q;
   logic [7:0]       scratch_adj;
   logic [7:0]       scratch_d;
   logic [CW-1:0]    count_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [7:0]       bcd_q;
   logic [6:0]       hex0_q;
   logic [6:0]       hex1_q;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // One double-dabble step: correct nibbles, then shift in the next binary MSB.
   always_comb begin
      scratch_adj = {add3(scratch_q[7:4]), add3(scratch_q[3:0])};
      scratch_d   = {scratch_adj[6:0], bin_q[WIDTH-1]};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         scratch_q   <= '0;
         count_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         bcd_q       <= 8'h00;
         hex0_q      <= SEG_ZERO;
         hex1_q      <= HEX1_RST;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  bin_q      <= in_data;
                  scratch_q  <= '0;
                  count_q    <= CW'(WIDTH);
                  in_ready_q <= 1'b0;
                  state_q    <= CONV;
               end
            end
            CONV: begin
               scratch_q <= scratch_d;
               bin_q     <= bin_q << 1;
               count_q   <= count_q - CW'(1);
               // Last shift: publish the finished digits on this same edge.
               if (count_q == CW'(1)) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  bcd_q       <= scratch_d;
                  hex0_q      <= seg7(scratch_d[3:0]);
                  hex1_q      <= (BLANK_LZ && scratch_d[7:4] == 4'd0) ? SEG_BLANK
                                                                      : seg7(scratch_d[7:4]);
               end
            end
            DONE: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign bcd_out   = bcd_q;
   assign HEX0      = hex0_q;
   assign HEX1      = hex1_q;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Directed bench for sum_bcd_display: one blanking and one non-blanking instance
// run in lockstep on the same stimulus.
module tb_sum_bcd_display;

   logic       clk;
   logic       resetn;
   logic       in_valid;
   logic [4:0] in_data;
   logic       in_ready,  out_valid;
   logic [7:0] bcd_out;
   logic [6:0] HEX0, HEX1;
   logic       b_in_ready, b_out_valid;
   logic [7:0] b_bcd_out;
   logic [6:0] b_HEX0, b_HEX1;

   int n_vec = 0;
   int n_err = 0;

   sum_bcd_display #(.WIDTH(5), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .bcd_out(bcd_out),
      .HEX0(HEX0), .HEX1(HEX1));

   sum_bcd_display #(.WIDTH(5), .BLANK_LZ(1'b0)) dut_b (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
      .in_ready(b_in_ready), .out_valid(b_out_valid), .bcd_out(b_bcd_out),
      .HEX0(b_HEX0), .HEX1(b_HEX1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] exp_seg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Waits for in_ready, pulses one value, returns the edge count to out_valid (0 = timeout).
   task automatic convert(input logic [4:0] v, output int lat);
      lat = 0;
      for (int i = 0; i < 20 && !in_ready; i++) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      resetn   = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", in_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", out_valid); end
      n_vec++; if (bcd_out !== 8'h00) begin n_err++; $display("FAIL reset_bcd got %h exp 00", bcd_out); end
      n_vec++; if (HEX0 !== 7'b1000000) begin n_err++; $display("FAIL reset_hex0 got %b exp 1000000", HEX0); end
      n_vec++; if (HEX1 !== 7'b1111111) begin n_err++; $display("FAIL reset_hex1 got %b exp 1111111", HEX1); end
      n_vec++; if (b_HEX1 !== 7'b1000000) begin n_err++; $display("FAIL reset_hex1_nb got %b exp 1000000", b_HEX1); end
   endtask

   task automatic test_single();
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 5'd31;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL single_ready_e0 got %b exp 0", in_ready); end
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); #1;
         n_vec++;
         if (out_valid !== (i == 5)) begin n_err++; $display("FAIL single_valid_e%0d got %b exp %b", i, out_valid, (i == 5)); end
         n_vec++;
         if (in_ready !== (i == 6)) begin n_err++; $display("FAIL single_ready_e%0d got %b exp %b", i, in_ready, (i == 6)); end
         if (i == 5) begin
            n_vec++; if (bcd_out !== 8'h31) begin n_err++; $display("FAIL single_bcd got %h exp 31", bcd_out); end
            n_vec++; if (HEX1 !== 7'b0110000) begin n_err++; $display("FAIL single_hex1 got %b exp 0110000", HEX1); end
            n_vec++; if (HEX0 !== 7'b1111001) begin n_err++; $display("FAIL single_hex0 got %b exp 1111001", HEX0); end
         end
      end
   endtask

   task automatic test_boundaries();
      logic [4:0] vals [3]  = '{5'd0, 5'd9, 5'd10};
      logic [7:0] ebcd [3]  = '{8'h00, 8'h09, 8'h10};
      logic [6:0] eh0 [3]   = '{7'b1000000, 7'b0010000, 7'b1000000};
      logic [6:0] eh1 [3]   = '{7'b1111111, 7'b1111111, 7'b1111001};
      logic [6:0] eh1nb [3] = '{7'b1000000, 7'b1000000, 7'b1111001};
      int lat;
      for (int k = 0; k < 3; k++) begin
         convert(vals[k], lat);
         n_vec++; if (lat != 5) begin n_err++; $display("FAIL bound_lat v=%0d got %0d exp 5", vals[k], lat); end
         n_vec++; if (bcd_out !== ebcd[k]) begin n_err++; $display("FAIL bound_bcd v=%0d got %h exp %h", vals[k], bcd_out, ebcd[k]); end
         n_vec++; if (HEX0 !== eh0[k]) begin n_err++; $display("FAIL bound_hex0 v=%0d got %b exp %b", vals[k], HEX0, eh0[k]); end
         n_vec++; if (HEX1 !== eh1[k]) begin n_err++; $display("FAIL bound_hex1 v=%0d got %b exp %b", vals[k], HEX1, eh1[k]); end
         n_vec++; if (b_HEX1 !== eh1nb[k]) begin n_err++; $display("FAIL bound_hex1_nb v=%0d got %b exp %b", vals[k], b_HEX1, eh1nb[k]); end
         n_vec++; if (b_bcd_out !== ebcd[k]) begin n_err++; $display("FAIL bound_bcd_nb v=%0d got %h exp %h", vals[k], b_bcd_out, ebcd[k]); end
      end
   endtask

   task automatic test_back_to_back();
      int nv = 0;
      for (int i = 0; i < 20 && !in_ready; i++) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = 5'd12;
      @(posedge clk); #1;
      in_data = 5'd25;
      for (int i = 1; i <= 14; i++) begin
         @(posedge clk); #1;
         if (i == 7) in_valid = 1'b0;
         if (out_valid) nv++;
         if (i == 5) begin
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid1 got %b exp 1", out_valid); end
            n_vec++; if (bcd_out !== 8'h12) begin n_err++; $display("FAIL b2b_bcd1 got %h exp 12", bcd_out); end
         end
         if (i == 6) begin
            n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready6 got %b exp 1", in_ready); end
         end
         if (i == 7) begin
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_reaccept got %b exp 0", in_ready); end
         end
         if (i == 12) begin
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid2 got %b exp 1", out_valid); end
            n_vec++; if (bcd_out !== 8'h25) begin n_err++; $display("FAIL b2b_bcd2 got %h exp 25", bcd_out); end
            n_vec++; if (HEX1 !== 7'b0100100) begin n_err++; $display("FAIL b2b_hex1 got %b exp 0100100", HEX1); end
            n_vec++; if (HEX0 !== 7'b0010010) begin n_err++; $display("FAIL b2b_hex0 got %b exp 0010010", HEX0); end
         end
      end
      n_vec++; if (nv != 2) begin n_err++; $display("FAIL b2b_pulses got %0d exp 2", nv); end
   endtask

   task automatic test_mid_reset();
      int nv = 0;
      int lat;
      for (int i = 0; i < 20 && !in_ready; i++) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = 5'd27;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      n_vec++; if (bcd_out !== 8'h00) begin n_err++; $display("FAIL midrst_bcd got %h exp 00", bcd_out); end
      n_vec++; if (HEX0 !== 7'b1000000) begin n_err++; $display("FAIL midrst_hex0 got %b exp 1000000", HEX0); end
      n_vec++; if (HEX1 !== 7'b1111111) begin n_err++; $display("FAIL midrst_hex1 got %b exp 1111111", HEX1); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %b exp 1", in_ready); end
      for (int i = 0; i < 8; i++) begin
         if (out_valid) nv++;
         @(posedge clk); #1;
      end
      n_vec++; if (nv != 0) begin n_err++; $display("FAIL midrst_pulses got %0d exp 0", nv); end
      convert(5'd17, lat);
      n_vec++; if (lat != 5) begin n_err++; $display("FAIL midrst_lat got %0d exp 5", lat); end
      n_vec++; if (bcd_out !== 8'h17) begin n_err++; $display("FAIL midrst_bcd17 got %h exp 17", bcd_out); end
   endtask

   task automatic test_exhaustive();
      int lat;
      logic [7:0] ebcd;
      logic [6:0] eh1;
      for (int v = 0; v < 32; v++) begin
         ebcd = {4'(v / 10), 4'(v % 10)};
         eh1  = (v / 10 == 0) ? 7'b1111111 : exp_seg(v / 10);
         convert(5'(v), lat);
         n_vec++; if (lat != 5) begin n_err++; $display("FAIL exh_lat v=%0d got %0d exp 5", v, lat); end
         n_vec++; if (bcd_out !== ebcd) begin n_err++; $display("FAIL exh_bcd v=%0d got %h exp %h", v, bcd_out, ebcd); end
         n_vec++; if (HEX0 !== exp_seg(v % 10)) begin n_err++; $display("FAIL exh_hex0 v=%0d got %b exp %b", v, HEX0, exp_seg(v % 10)); end
         n_vec++; if (HEX1 !== eh1) begin n_err++; $display("FAIL exh_hex1 v=%0d got %b exp %b", v, HEX1, eh1); end
         n_vec++; if (b_HEX1 !== exp_seg(v / 10)) begin n_err++; $display("FAIL exh_hex1_nb v=%0d got %b exp %b", v, b_HEX1, exp_seg(v / 10)); end
         @(posedge clk); #1;
         n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL exh_pulse v=%0d got %b exp 0", v, out_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_boundaries();
      test_back_to_back();
      test_mid_reset();
      test_exhaustive();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
